// File: rtl/interrupt_ack_sequencer.sv
// CPU-side INT/INTA responder for an 8259A-compatible controller: runs the two-pulse
// acknowledge, maintains the in-service register and drives the vector. Optional AEOI via PIC_AUTO_EOI_EN.
module interrupt_ack_sequencer #(
  parameter int VECTOR_W = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          interrupt,
  input  logic                inta_n,
  input  logic [VECTOR_W-1:0] vector_base,
  input  logic                auto_eoi,
  input  logic                eoi_nonspecific,
  input  logic                eoi_specific,
  input  logic [2:0]          eoi_level,
  output logic                int_out,
  output logic [7:0]          isr,
  output logic [7:0]          clear_irr,
  output logic [7:0]          data_out,
  output logic                data_out_en
);

  typedef enum logic [2:0] {
    IDLE,
    PEND,
    ACK1,
    WAIT2,
    ACK2
  } state_t;

  state_t     state;
  logic       inta_prev;
  logic       inta_fall;
  logic       inta_rise;
  logic [2:0] cur_level;
  logic       spurious;
  logic       req_valid;
  logic [2:0] req_level;
  logic       eligible;
  logic [7:0] isr_set;
  logic [7:0] eoi_clr;
  logic [7:0] aeoi_clr;

  // Bit 0 is the highest priority, so the lowest set index wins.
  function automatic logic [2:0] lowest_level(input logic [7:0] v);
    lowest_level = 3'd7;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) lowest_level = 3'(i);
    end
  endfunction

  assign inta_fall = inta_prev & ~inta_n;
  assign inta_rise = ~inta_prev & inta_n;
  assign req_valid = |interrupt;
  assign req_level = lowest_level(interrupt);

  // A request may not nest on itself or on any higher-priority level in service.
  assign eligible = ((isr & (8'hFF >> (3'd7 - req_level))) == 8'h00);

  // NOTE: every always_comb output is assigned a default first so no latch is inferred.
  always_comb begin
    isr_set = 8'h00;
    if (state == PEND && inta_fall && req_valid) isr_set = 8'h01 << req_level;
  end

  // Specific EOI outranks non-specific; x & -x isolates the lowest set ISR bit.
  always_comb begin
    eoi_clr = 8'h00;
    if (eoi_specific)         eoi_clr = 8'h01 << eoi_level;
    else if (eoi_nonspecific) eoi_clr = isr & (~isr + 8'h01);
  end

`ifdef PIC_AUTO_EOI_EN
  always_comb begin
    aeoi_clr = 8'h00;
    if (state == ACK2 && inta_rise && auto_eoi && !spurious) aeoi_clr = 8'h01 << cur_level;
  end
`else
  logic unused_aeoi;
  assign aeoi_clr    = 8'h00;
  assign unused_aeoi = auto_eoi | spurious;
`endif

  // Clears are taken from the pre-update ISR; a same-cycle set overrides them.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) isr <= 8'h00;
    else       isr <= (isr & ~(eoi_clr | aeoi_clr)) | isr_set;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      inta_prev   <= 1'b1;
      cur_level   <= 3'd0;
      spurious    <= 1'b0;
      int_out     <= 1'b0;
      clear_irr   <= 8'h00;
      data_out    <= 8'h00;
      data_out_en <= 1'b0;
    end else begin
      inta_prev <= inta_n;
      clear_irr <= 8'h00;
      case (state)
        IDLE: begin
          if (req_valid && eligible) begin
            state   <= PEND;
            int_out <= 1'b1;
          end
        end
        PEND: begin
          if (inta_fall) begin
            state   <= ACK1;
            int_out <= 1'b0;
            if (req_valid) begin
              cur_level <= req_level;
              spurious  <= 1'b0;
              clear_irr <= 8'h01 << req_level;
            end else begin
              // Request vanished before the acknowledge: answer with level 7, touch nothing.
              cur_level <= 3'd7;
              spurious  <= 1'b1;
            end
          end
        end
        ACK1: begin
          if (inta_rise) state <= WAIT2;
        end
        WAIT2: begin
          if (inta_fall) begin
            state       <= ACK2;
            data_out    <= 8'({vector_base, cur_level});
            data_out_en <= 1'b1;
          end
        end
        ACK2: begin
          if (inta_rise) begin
            state       <= IDLE;
            data_out_en <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Self-checking bench for interrupt_ack_sequencer: scoreboard queues hold expected
// clear_irr pulses and vectors, compared by a negedge monitor as the DUT produces them.
module tb_interrupt_ack_sequencer;

  logic       clk;
  logic       reset;
  logic [7:0] interrupt;
  logic       inta_n;
  logic [4:0] vector_base;
  logic       auto_eoi;
  logic       eoi_nonspecific;
  logic       eoi_specific;
  logic [2:0] eoi_level;
  logic       int_out;
  logic [7:0] isr;
  logic [7:0] clear_irr;
  logic [7:0] data_out;
  logic       data_out_en;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_clr[$];
  logic [7:0] exp_vec[$];
  logic [7:0] mon_exp;
  logic       prev_en;

  interrupt_ack_sequencer #(.VECTOR_W(5)) dut (
    .clk             (clk),
    .reset           (reset),
    .interrupt       (interrupt),
    .inta_n          (inta_n),
    .vector_base     (vector_base),
    .auto_eoi        (auto_eoi),
    .eoi_nonspecific (eoi_nonspecific),
    .eoi_specific    (eoi_specific),
    .eoi_level       (eoi_level),
    .int_out         (int_out),
    .isr             (isr),
    .clear_irr       (clear_irr),
    .data_out        (data_out),
    .data_out_en     (data_out_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  // Monitor: every clear_irr pulse and every data_out_en rise must match the next queued entry.
  always @(negedge clk) begin
    if (reset) begin
      prev_en = 1'b0;
    end else begin
      if (clear_irr !== 8'h00) begin
        checks++;
        if (exp_clr.size() == 0) begin
          errors++;
          $display("FAIL clear_irr_unexpected: got %h, expected no pulse", clear_irr);
        end else begin
          mon_exp = exp_clr.pop_front();
          if (clear_irr !== mon_exp) begin
            errors++;
            $display("FAIL clear_irr: got %h expected %h", clear_irr, mon_exp);
          end
        end
      end
      if (data_out_en === 1'b1 && prev_en !== 1'b1) begin
        checks++;
        if (exp_vec.size() == 0) begin
          errors++;
          $display("FAIL vector_unexpected: got %h, expected no drive", data_out);
        end else begin
          mon_exp = exp_vec.pop_front();
          if (data_out !== mon_exp) begin
            errors++;
            $display("FAIL vector: got %h expected %h", data_out, mon_exp);
          end
        end
      end
      prev_en = data_out_en;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full acknowledge of request req at level lvl; spurious drops the request before INTA.
  task automatic run_ack(input logic [7:0] req, input logic [2:0] lvl, input logic spur);
    logic [7:0] m;
    interrupt = req;
    tick();
    checks++;
    if (int_out !== 1'b1) begin errors++; $display("FAIL int_raise: got %b expected 1", int_out); end
    m = 8'h01 << lvl;
    if (!spur) exp_clr.push_back(m);
    exp_vec.push_back({vector_base, lvl});
    if (spur) begin
      interrupt = 8'h00;
      tick();
      checks++;
      if (int_out !== 1'b1) begin errors++; $display("FAIL int_hold_withdrawn: got %b expected 1", int_out); end
    end
    inta_n = 1'b0;
    tick();
    interrupt = 8'h00;
    checks++;
    if (int_out !== 1'b0) begin errors++; $display("FAIL int_drop: got %b expected 0", int_out); end
    tick();
    inta_n = 1'b1;
    tick();
    tick();
    inta_n = 1'b0;
    tick();
    tick();
    inta_n = 1'b1;
    tick();
    checks++;
    if (data_out_en !== 1'b0) begin errors++; $display("FAIL en_release: got %b expected 0", data_out_en); end
  endtask

  task automatic eoi_pulse(input logic ns, input logic sp, input logic [2:0] lvl);
    eoi_nonspecific = ns;
    eoi_specific    = sp;
    eoi_level       = lvl;
    tick();
    eoi_nonspecific = 1'b0;
    eoi_specific    = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (int_out !== 1'b0) begin errors++; $display("FAIL reset_int: got %b expected 0", int_out); end
    checks++;
    if (isr !== 8'h00) begin errors++; $display("FAIL reset_isr: got %h expected 00", isr); end
    checks++;
    if (clear_irr !== 8'h00) begin errors++; $display("FAIL reset_clr: got %h expected 00", clear_irr); end
    checks++;
    if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", data_out); end
    checks++;
    if (data_out_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b expected 0", data_out_en); end
  endtask

  task automatic test_basic();
    vector_base = 5'b01000;
    interrupt   = 8'h08;
    tick();
    checks++;
    if (int_out !== 1'b1) begin errors++; $display("FAIL basic_int: got %b expected 1", int_out); end
    exp_clr.push_back(8'h08);
    exp_vec.push_back(8'h43);
    inta_n = 1'b0;
    tick();
    interrupt = 8'h00;
    checks++;
    if (int_out !== 1'b0) begin errors++; $display("FAIL basic_int_drop: got %b expected 0", int_out); end
    checks++;
    if (isr !== 8'h08) begin errors++; $display("FAIL basic_isr: got %h expected 08", isr); end
    tick();
    checks++;
    if (clear_irr !== 8'h00) begin errors++; $display("FAIL basic_clr_width: got %h expected 00", clear_irr); end
    inta_n = 1'b1;
    tick();
    tick();
    inta_n = 1'b0;
    tick();
    checks++;
    if (data_out_en !== 1'b1 || data_out !== 8'h43) begin
      errors++; $display("FAIL basic_drive: got en=%b data=%h expected en=1 data=43", data_out_en, data_out);
    end
    tick();
    inta_n = 1'b1;
    tick();
    checks++;
    if (data_out_en !== 1'b0 || data_out !== 8'h43) begin
      errors++; $display("FAIL basic_release: got en=%b data=%h expected en=0 data=43", data_out_en, data_out);
    end
    eoi_pulse(1'b0, 1'b1, 3'd3);
    checks++;
    if (isr !== 8'h00) begin errors++; $display("FAIL basic_eoi: got %h expected 00", isr); end
  endtask

  task automatic test_blocking();
    run_ack(8'h02, 3'd1, 1'b0);
    checks++;
    if (isr !== 8'h02) begin errors++; $display("FAIL block_isr: got %h expected 02", isr); end
    interrupt = 8'h04;
    tick();
    tick();
    checks++;
    if (int_out !== 1'b0) begin errors++; $display("FAIL block_lower: got %b expected 0", int_out); end
    run_ack(8'h01, 3'd0, 1'b0);
    checks++;
    if (isr !== 8'h03) begin errors++; $display("FAIL block_nest_isr: got %h expected 03", isr); end
    eoi_pulse(1'b1, 1'b0, 3'd0);
    checks++;
    if (isr !== 8'h02) begin errors++; $display("FAIL block_ns_eoi1: got %h expected 02", isr); end
    eoi_pulse(1'b1, 1'b0, 3'd0);
    checks++;
    if (isr !== 8'h00) begin errors++; $display("FAIL block_ns_eoi2: got %h expected 00", isr); end
    eoi_pulse(1'b1, 1'b0, 3'd0);
    checks++;
    if (isr !== 8'h00) begin errors++; $display("FAIL block_ns_empty: got %h expected 00", isr); end
  endtask

  task automatic test_spurious();
    vector_base = 5'b10101;
    run_ack(8'h10, 3'd7, 1'b1);
    checks++;
    if (isr !== 8'h00) begin errors++; $display("FAIL spurious_isr: got %h expected 00", isr); end
  endtask

  task automatic test_aeoi();
    logic [7:0] exp_isr;
`ifdef PIC_AUTO_EOI_EN
    exp_isr = 8'h00;
`else
    exp_isr = 8'h20;
`endif
    auto_eoi = 1'b1;
    run_ack(8'h20, 3'd5, 1'b0);
    auto_eoi = 1'b0;
    checks++;
    if (isr !== exp_isr) begin errors++; $display("FAIL aeoi_isr: got %h expected %h", isr, exp_isr); end
    eoi_pulse(1'b0, 1'b1, 3'd5);
  endtask

  task automatic test_eoi();
    run_ack(8'h20, 3'd5, 1'b0);
    run_ack(8'h04, 3'd2, 1'b0);
    checks++;
    if (isr !== 8'h24) begin errors++; $display("FAIL eoi_setup: got %h expected 24", isr); end
    eoi_pulse(1'b1, 1'b0, 3'd0);
    checks++;
    if (isr !== 8'h20) begin errors++; $display("FAIL eoi_nonspecific: got %h expected 20", isr); end
    eoi_pulse(1'b0, 1'b1, 3'd5);
    checks++;
    if (isr !== 8'h00) begin errors++; $display("FAIL eoi_specific: got %h expected 00", isr); end
    // Specific EOI on the very cycle isr[3] is set: the set must survive.
    interrupt = 8'h08;
    tick();
    exp_clr.push_back(8'h08);
    exp_vec.push_back({vector_base, 3'd3});
    inta_n          = 1'b0;
    eoi_specific    = 1'b1;
    eoi_level       = 3'd3;
    tick();
    eoi_specific = 1'b0;
    interrupt    = 8'h00;
    checks++;
    if (isr !== 8'h08) begin errors++; $display("FAIL eoi_set_wins: got %h expected 08", isr); end
    tick();
    inta_n = 1'b1;
    tick();
    tick();
    inta_n = 1'b0;
    tick();
    tick();
    inta_n = 1'b1;
    tick();
    eoi_pulse(1'b1, 1'b1, 3'd5);
    checks++;
    if (isr !== 8'h08) begin errors++; $display("FAIL eoi_specific_wins: got %h expected 08", isr); end
    eoi_pulse(1'b0, 1'b1, 3'd3);
    checks++;
    if (isr !== 8'h00) begin errors++; $display("FAIL eoi_final: got %h expected 00", isr); end
  endtask

  task automatic test_reset_wait2();
    interrupt = 8'h10;
    tick();
    exp_clr.push_back(8'h10);
    inta_n = 1'b0;
    tick();
    interrupt = 8'h00;
    checks++;
    if (isr !== 8'h10) begin errors++; $display("FAIL rst_setup_isr: got %h expected 10", isr); end
    tick();
    inta_n = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if (int_out !== 1'b0 || isr !== 8'h00 || clear_irr !== 8'h00 || data_out !== 8'h00 || data_out_en !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: got int=%b isr=%h clr=%h data=%h en=%b expected all 0",
               int_out, isr, clear_irr, data_out, data_out_en);
    end
    tick();
    reset = 1'b0;
    tick();
    inta_n = 1'b0;
    tick();
    tick();
    checks++;
    if (int_out !== 1'b0 || isr !== 8'h00 || data_out_en !== 1'b0) begin
      errors++; $display("FAIL rst_no_resp1: got int=%b isr=%h en=%b expected 0/00/0", int_out, isr, data_out_en);
    end
    inta_n = 1'b1;
    tick();
    tick();
    checks++;
    if (data_out_en !== 1'b0 || data_out !== 8'h00) begin
      errors++; $display("FAIL rst_no_resp2: got en=%b data=%h expected 0/00", data_out_en, data_out);
    end
  endtask

  initial begin
    reset           = 1'b1;
    interrupt       = 8'h00;
    inta_n          = 1'b1;
    vector_base     = 5'b00000;
    auto_eoi        = 1'b0;
    eoi_nonspecific = 1'b0;
    eoi_specific    = 1'b0;
    eoi_level       = 3'd0;
    prev_en         = 1'b0;
    tick();
    tick();
    test_reset();
    reset = 1'b0;
    tick();
    test_reset();
    test_basic();
    test_blocking();
    test_spurious();
    test_aeoi();
    test_eoi();
    test_reset_wait2();
    tick();
    checks++;
    if (exp_clr.size() != 0) begin errors++; $display("FAIL sb_clr_leftover: got %0d pending expected 0", exp_clr.size()); end
    checks++;
    if (exp_vec.size() != 0) begin errors++; $display("FAIL sb_vec_leftover: got %0d pending expected 0", exp_vec.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/interrupt_ack_sequencer.md
# interrupt_ack_sequencer

CPU-side responder for the 8259A-compatible interrupt controller. Takes the one-hot winning request from the priority resolver, raises INT to the CPU, and runs the two-pulse 8086-style INTA handshake. On the handshake it sets the in-service register (ISR), issues a clear pulse to the interrupt request register (IRR), and drives the interrupt vector onto the data bus. It also owns ISR maintenance for end-of-interrupt (EOI) commands from the control-word logic.

## Interface
- VECTOR_W, 5, width of the vector base (T7..T3) taken from ICW2
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- interrupt  in  8  one-hot request from the priority resolver, already masked; bit 0 is highest priority
- inta_n  in  1  CPU interrupt acknowledge, active-low, already synchronous to clk
- vector_base  in  VECTOR_W  ICW2[7:3]
- auto_eoi  in  1  ICW4 AEOI bit
- eoi_nonspecific  in  1  one-cycle pulse: clear the highest-priority ISR bit
- eoi_specific  in  1  one-cycle pulse: clear ISR[eoi_level]
- eoi_level  in  3  level for specific EOI
- int_out  out  1  INT to CPU
- isr  out  8  in-service register
- clear_irr  out  8  one-cycle one-hot pulse to clear the acknowledged IRR bit
- data_out  out  8  vector byte
- data_out_en  out  1  data bus drive enable

## Operation
- Reset values: int_out=0, isr=0, clear_irr=0, data_out=0, data_out_en=0. State is IDLE.
- If `interrupt` has more than one bit set, the lowest index wins. That index is the request level L.
- Eligibility: L is eligible only when isr[L:0]==0. A request never nests on itself or on a higher-priority level.
- FSM states: IDLE, PEND, ACK1, WAIT2, ACK2.
  - IDLE -> PEND when an eligible request is present. int_out is set to 1.
  - PEND -> ACK1 on the sampled falling edge of inta_n. Edge = inta_prev & ~inta_n, with inta_prev=1 at reset. On that edge:
    - Latch L.
    - Set isr[L].
    - Pulse clear_irr[L].
    - Clear int_out.
  - PEND -> ACK1 with an empty request: if `interrupt`==0 at the falling edge, the acknowledge is spurious. Latch L=7 and leave isr and clear_irr unchanged.
  - PEND with the request withdrawn and inta_n still high: int_out stays 1. The spurious rule above handles the eventual acknowledge.
  - ACK1 -> WAIT2 on the rising edge of inta_n.
  - WAIT2 -> ACK2 on the falling edge. Drive data_out={vector_base, L} and set data_out_en=1.
  - ACK2 -> IDLE on the rising edge. Clear data_out_en and hold data_out. If AEOI is active and the acknowledge was not spurious, clear isr[L].
- EOI handling:
  - Non-specific EOI clears the lowest-index set ISR bit. It is a no-op when isr==0.
  - Specific EOI clears isr[eoi_level].
  - If both pulses arrive in the same cycle, specific wins.
  - EOI is evaluated on the pre-update ISR. A set of isr[L] in the same cycle wins over a clear of the same bit.
- EOI is accepted in every FSM state.

## Timing
- int_out rises one cycle after an eligible request appears in IDLE.
- A falling edge of inta_n sampled at edge N produces isr, clear_irr and int_out updates visible after edge N. clear_irr is high for exactly one cycle.
- data_out_en is high from the cycle after the second falling edge is sampled through the cycle in which the rising edge is sampled.
- From ACK2 -> IDLE, a new eligible request can raise int_out after one idle cycle at the earliest.
- inta_n low pulses shorter than one clock are out of spec.
- Asserting reset in any state returns the block to IDLE immediately. All outputs take their reset values and isr is cleared.

## Configuration
- Macro: PIC_AUTO_EOI_EN.
- Defined: auto_eoi is honoured as described above.
- Undefined: the auto_eoi port remains but is ignored. ISR bits clear only through EOI pulses.

## Test plan
- Basic acknowledge:
  - Stimulus: vector_base=5'b01000, interrupt=8'h08, two inta_n pulses.
  - Response: int_out=1, then 0 after the first pulse. clear_irr=8'h08 for one cycle. isr=8'h08. data_out=8'h43 with data_out_en during the second pulse.
- Blocking: with isr=8'h02, interrupt=8'h04 leaves int_out at 0. interrupt=8'h01 raises int_out.
- Spurious acknowledge:
  - Stimulus: interrupt drops to 0 after int_out rises, then two inta_n pulses.
  - Response: data_out={vector_base,3'd7}. isr and clear_irr unchanged.
- AEOI:
  - Stimulus: PIC_AUTO_EOI_EN defined, auto_eoi=1, level 5 acknowledged.
  - Response: isr=0 after the second rising edge. With the macro undefined, isr stays 8'h20.
- EOI:
  - isr=8'h24 plus a non-specific EOI gives 8'h20.
  - A specific EOI with eoi_level=5 then gives 8'h00.
  - A specific EOI on the cycle isr[3] is set leaves isr[3]=1.
- Reset: assert reset during WAIT2 with isr=8'h10. All outputs go to 0 and the next inta_n pulse causes no response.
